// File: rtl/triangle_assemble.sv
// triangle_assemble
//   Groups every three consecutive valid vertices of the clipped-vertex stream
//   into one triangle packet, queues packets in a DEPTH-entry FIFO and presents
//   the head packet downstream with a valid/ready handshake. The upstream has
//   no backpressure: a triangle that completes while the FIFO is full (and no
//   pop happens that cycle) is dropped whole and overflow_out is set (sticky).
//
// Ports
//   clk_in         clock, all logic on posedge
//   rst_in         synchronous active-high reset
//   valid_in       vertex present this cycle
//   position_in    clip-space x,y,z,w fp32, [3]=w
//   normal_in      normal index
//   material_in    material index
//   ready_in       downstream accepts the head triangle
//   valid_out      head triangle available
//   positions_out  vertex 0..2 positions, [0]=first received
//   normals_out    vertex 0..2 normal indices
//   material_out   material of vertex 0
//   overflow_out   sticky: a triangle was dropped
//
// Optional feature (macro TRIANGLE_ASSEMBLE_STATS_EN):
//   tri_count_out  [31:0] accepted pushes, wraps
//   drop_count_out [15:0] dropped triangles, saturates at 16'hFFFF

module triangle_assemble #(
  parameter int DEPTH = 4
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   valid_in,
  input  logic [3:0][31:0]       position_in,
  input  logic [11:0]            normal_in,
  input  logic [11:0]            material_in,
  input  logic                   ready_in,
  output logic                   valid_out,
  output logic [2:0][3:0][31:0]  positions_out,
  output logic [2:0][11:0]       normals_out,
  output logic [11:0]            material_out,
  output logic                   overflow_out
`ifdef TRIANGLE_ASSEMBLE_STATS_EN
  ,
  output logic [31:0]            tri_count_out,
  output logic [15:0]            drop_count_out
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [2:0][3:0][31:0] pos;
    logic [2:0][11:0]      nrm;
    logic [11:0]           mat;
  } tri_t;

  // Slots for the first two vertices of the triangle being collected; the
  // third vertex goes straight into the FIFO entry.
  logic [1:0][3:0][31:0] slot_pos_q;
  logic [1:0][11:0]      slot_nrm_q;
  logic [11:0]           slot_mat_q;

  logic [1:0]    vertex_index_q, vertex_index_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;

  tri_t fifo_q [DEPTH];
  tri_t new_tri;

  logic push_req, pop, full, push_ok, drop;

  always_comb begin
    new_tri.pos = {position_in, slot_pos_q[1], slot_pos_q[0]};
    new_tri.nrm = {normal_in, slot_nrm_q[1], slot_nrm_q[0]};
    new_tri.mat = slot_mat_q;
  end

  always_comb begin
    push_req = valid_in && (vertex_index_q == 2'd2);
    pop      = valid_out && ready_in;
    full     = (count_q == CW'(DEPTH));
    // A full FIFO still accepts when the head leaves in the same cycle.
    push_ok  = push_req && (!full || pop);
    drop     = push_req && full && !pop;

    vertex_index_d = vertex_index_q;
    if (valid_in) begin
      vertex_index_d = (vertex_index_q == 2'd2) ? 2'd0 : vertex_index_q + 2'd1;
    end
    wr_ptr_d   = push_ok ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d    = count_q + CW'(push_ok) - CW'(pop);
    overflow_d = overflow_q | drop;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      vertex_index_q <= 2'd0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      overflow_q     <= 1'b0;
    end else begin
      vertex_index_q <= vertex_index_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      overflow_q     <= overflow_d;
    end
  end

  // Data storage needs no reset: it is only observed while valid_out=1.
  always_ff @(posedge clk_in) begin
    if (valid_in && vertex_index_q != 2'd2) begin
      slot_pos_q[vertex_index_q[0]] <= position_in;
      slot_nrm_q[vertex_index_q[0]] <= normal_in;
      if (vertex_index_q == 2'd0) begin
        slot_mat_q <= material_in;
      end
    end
    if (push_ok) begin
      fifo_q[wr_ptr_q] <= new_tri;
    end
  end

  assign valid_out     = (count_q != '0);
  assign positions_out = fifo_q[rd_ptr_q].pos;
  assign normals_out   = fifo_q[rd_ptr_q].nrm;
  assign material_out  = fifo_q[rd_ptr_q].mat;
  assign overflow_out  = overflow_q;

`ifdef TRIANGLE_ASSEMBLE_STATS_EN
  logic [31:0] tri_count_q;
  logic [15:0] drop_count_q;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      tri_count_q  <= '0;
      drop_count_q <= '0;
    end else begin
      if (push_ok) tri_count_q <= tri_count_q + 32'd1;
      if (drop && drop_count_q != 16'hFFFF) drop_count_q <= drop_count_q + 16'd1;
    end
  end

  assign tri_count_out  = tri_count_q;
  assign drop_count_out = drop_count_q;
`endif

endmodule

// File: tb/tb_triangle_assemble.sv
module tb_triangle_assemble;

  localparam int DEPTH = 4;

  logic                  clk_in = 1'b0;
  logic                  rst_in = 1'b1;
  logic                  valid_in = 1'b0;
  logic [3:0][31:0]      position_in = '0;
  logic [11:0]           normal_in = '0;
  logic [11:0]           material_in = '0;
  logic                  ready_in = 1'b0;
  logic                  valid_out;
  logic [2:0][3:0][31:0] positions_out;
  logic [2:0][11:0]      normals_out;
  logic [11:0]           material_out;
  logic                  overflow_out;
`ifdef TRIANGLE_ASSEMBLE_STATS_EN
  logic [31:0]           tri_count_out;
  logic [15:0]           drop_count_out;
`endif

  triangle_assemble #(.DEPTH(DEPTH)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .valid_in(valid_in),
    .position_in(position_in), .normal_in(normal_in), .material_in(material_in),
    .ready_in(ready_in), .valid_out(valid_out), .positions_out(positions_out),
    .normals_out(normals_out), .material_out(material_out), .overflow_out(overflow_out)
`ifdef TRIANGLE_ASSEMBLE_STATS_EN
    , .tri_count_out(tri_count_out), .drop_count_out(drop_count_out)
`endif
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [3:0][31:0] p;
    logic [11:0]      n;
    logic [11:0]      m;
  } vtx_t;

  typedef struct {
    logic [2:0][3:0][31:0] p;
    logic [2:0][11:0]      n;
    logic [11:0]           m;
  } tri_t;

  int total = 0;
  int bad   = 0;

  // Reference model state: pending vertices, queued triangles, flags.
  vtx_t  verts [$];
  tri_t  sb [$];
  bit    exp_ovf = 0;
  int    exp_tri = 0;
  int    exp_drop = 0;
  bit    armed = 0;
  int    pops_seen = 0;

  task automatic chk(input string name, input logic [431:0] got, input logic [431:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s @%0t: got=%0h expected=%0h", name, $time, got, exp);
    end
  endtask

  // Monitor + model: outputs observed at negedge reflect the state after the
  // last posedge; the inputs seen here are what the next posedge will act on.
  always @(negedge clk_in) begin
    tri_t t;
    bit   popping;
    if (armed) begin
      chk("valid_out", 432'(valid_out), 432'(sb.size() != 0));
      chk("overflow_out", 432'(overflow_out), 432'(exp_ovf));
`ifdef TRIANGLE_ASSEMBLE_STATS_EN
      chk("tri_count", 432'(tri_count_out), 432'(32'(exp_tri)));
      chk("drop_count", 432'(drop_count_out), 432'(16'(exp_drop)));
`endif
      if (valid_out === 1'b1 && sb.size() != 0) begin
        chk("positions", 432'(positions_out), 432'(sb[0].p));
        chk("normals", 432'(normals_out), 432'(sb[0].n));
        chk("material", 432'(material_out), 432'(sb[0].m));
      end
    end
    if (rst_in) begin
      verts.delete();
      sb.delete();
      exp_ovf  = 0;
      exp_tri  = 0;
      exp_drop = 0;
      armed    = 1;
    end else if (armed) begin
      popping = (sb.size() != 0) && ready_in;
      if (popping) begin
        void'(sb.pop_front());
        pops_seen++;
      end
      if (valid_in) begin
        verts.push_back('{p: position_in, n: normal_in, m: material_in});
        if (verts.size() == 3) begin
          for (int k = 0; k < 3; k++) begin
            t.p[k] = verts[k].p;
            t.n[k] = verts[k].n;
          end
          t.m = verts[0].m;
          if (sb.size() < DEPTH) begin
            sb.push_back(t);
            exp_tri++;
          end else begin
            exp_ovf = 1;
            if (exp_drop < 16'hFFFF) exp_drop++;
          end
          verts.delete();
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle(input int n);
    valid_in = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send(input logic [11:0] n, input logic [31:0] w);
    valid_in    = 1'b1;
    position_in = {w, 32'($urandom), 32'($urandom), 32'($urandom)};
    normal_in   = n;
    material_in = 12'($urandom);
    tick();
    valid_in = 1'b0;
  endtask

  task automatic send_rand();
    send(12'($urandom), 32'($urandom));
  endtask

  task automatic do_reset();
    valid_in = 1'b0;
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
  endtask

  initial begin
    int pops_before;
    rst_in = 1'b1;
    tick();
    tick();
    rst_in = 1'b0;

    // 1: three back-to-back vertices, ready high
    ready_in = 1'b1;
    send(12'd1, 32'h3F800000);
    send(12'd2, 32'h3F800000);
    send(12'd3, 32'h3F800000);
    idle(3);
    total++;
    if (pops_seen != 1) begin
      bad++;
      $display("FAIL t1_pops: got=%0d expected=1", pops_seen);
    end

    // 2: six vertices with 2-cycle gaps
    for (int i = 0; i < 6; i++) begin
      send_rand();
      idle(2);
    end
    idle(2);
    total++;
    if (pops_seen != 3) begin
      bad++;
      $display("FAIL t2_pops: got=%0d expected=3", pops_seen);
    end

    // 3: five triangles into a stalled FIFO, then drain
    ready_in = 1'b0;
    for (int i = 0; i < 15; i++) send_rand();
    idle(3);
    ready_in = 1'b1;
    idle(8);

    // 4: full FIFO, pop in the same cycle as the third vertex
    do_reset();
    ready_in = 1'b0;
    for (int i = 0; i < 14; i++) send_rand();
    ready_in = 1'b1;
    send_rand();
    ready_in = 1'b0;
    idle(2);
    ready_in = 1'b1;
    idle(8);

    // 5: partial triangle lost to reset
    send_rand();
    send_rand();
    do_reset();
    for (int i = 0; i < 3; i++) send_rand();
    idle(3);

    // 6: stall 10 cycles with a triangle waiting, then drain
    ready_in = 1'b0;
    for (int i = 0; i < 6; i++) send_rand();
    idle(10);
    pops_before = pops_seen;
    ready_in = 1'b1;
    idle(4);
    total++;
    if (pops_seen - pops_before != 2) begin
      bad++;
      $display("FAIL t6_pops: got=%0d expected=2", pops_seen - pops_before);
    end

    // Random traffic with occasional reset
    for (int i = 0; i < 600; i++) begin
      rst_in      = ($urandom_range(0, 99) == 0);
      valid_in    = ($urandom_range(0, 2) != 0);
      ready_in    = ($urandom_range(0, 3) == 0);
      position_in = {32'($urandom), 32'($urandom), 32'($urandom), 32'($urandom)};
      normal_in   = 12'($urandom);
      material_in = 12'($urandom);
      tick();
    end
    rst_in = 1'b0;
    ready_in = 1'b1;
    idle(10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
